ps2_key_rx: RTL



---
 rtl/ps2_key_rx_if.sv | 22 ++
 rtl/ps2_key_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx_if.sv
// ps2_key_rx_if: PS/2 line inputs and key-event outputs of ps2_key_rx.
// master = the PS/2 device side (drives the lines), slave = the receiver.
interface ps2_key_rx_if;
  logic        ps2_clk_in;
  logic        ps2_data_in;
  logic [10:0] ps2_key;
  logic        frame_err;

  modport master (
    output ps2_clk_in,
    output ps2_data_in,
    input  ps2_key,
    input  frame_err
  );

  modport slave (
    input  ps2_clk_in,
    input  ps2_data_in,
    output ps2_key,
    output frame_err
  );
endinterface

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: PS/2 keyboard receiver producing the 11-bit ps2_key event word
// {toggle, pressed, extended, scancode}. Line synchroniser, glitch filter,
// frame FSM, watchdog and E0/F0 prefix decoder.
// Optional: define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module ps2_key_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic           clk_sys,
  input  logic           reset_n,
  ps2_key_rx_if.slave    bus
);

  localparam logic [7:0]  FLT_TERM = 8'(FILTER_LEN - 1);
  localparam logic [19:0] WD_TERM  = 20'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // Index 0 = PS/2 clock, index 1 = PS/2 data.
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] filt_q, filt_d;
  logic [7:0] fcnt_q [2];
  logic [7:0] fcnt_d [2];
  logic       clk_dly_q;
  logic       fall;
  logic       dat;

  state_t     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_q, parity_d;
  logic [19:0] wd_q, wd_d;
  logic       timeout;
  logic       frame_ok;

  logic       bit_clr, shift_en, par_en, deliver, frame_bad;

  logic       byte_vld_q;
  logic [7:0] byte_q, byte_d;
  logic       frame_err_q;

  logic [10:0] key_q, key_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;

  assign raw = {bus.ps2_data_in, bus.ps2_clk_in};

  // Two-flop synchroniser for both raw lines, idling high.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Filter: a line changes only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FLT_TERM) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Filter state and delayed filtered clock for edge detection.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      filt_q    <= '1;
      fcnt_q[0] <= '0;
      fcnt_q[1] <= '0;
      clk_dly_q <= 1'b1;
    end else begin
      filt_q    <= filt_d;
      fcnt_q[0] <= fcnt_d[0];
      fcnt_q[1] <= fcnt_d[1];
      clk_dly_q <= filt_q[0];
    end
  end

  assign fall = clk_dly_q & ~filt_q[0];
  assign dat  = filt_q[1];

  // A falling edge on the terminal count wins over the timeout.
  assign timeout = (state_q != ST_IDLE) && !fall && (wd_q == WD_TERM);

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = dat & (^{shift_q, parity_q});
`else
  assign frame_ok = dat;
`endif

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic: advances only on filtered clock falls or timeout.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (fall) begin
      case (state_q)
        ST_IDLE:   if (!dat) state_d = ST_DATA;
        ST_DATA:   if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: datapath enables, byte delivery and frame rejection.
  always_comb begin
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    if (fall) begin
      case (state_q)
        ST_IDLE:   bit_clr  = ~dat;
        ST_DATA:   shift_en = 1'b1;
        ST_PARITY: par_en   = 1'b1;
        ST_STOP: begin
          deliver   = frame_ok;
          frame_bad = ~frame_ok;
        end
        default: ;
      endcase
    end
  end

  // Shift register, bit counter, parity capture and watchdog next values.
  always_comb begin
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    if (bit_clr) begin
      bitcnt_d = '0;
    end
    if (shift_en) begin
      shift_d  = {dat, shift_q[7:1]};
      bitcnt_d = bitcnt_q + 3'd1;
    end
    if (par_en) begin
      parity_d = dat;
    end
    if (fall || state_q == ST_IDLE) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 20'd1;
    end
    byte_d = deliver ? shift_q : byte_q;
  end

  // Frame datapath, watchdog and registered delivery/error pulses.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      bitcnt_q    <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      wd_q        <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      wd_q        <= wd_d;
      byte_q      <= byte_d;
      byte_vld_q  <= deliver;
      frame_err_q <= frame_bad | timeout;
    end
  end

  // Prefix decoder: E0/F0 arm flags, any other byte emits a key event.
  always_comb begin
    key_d = key_q;
    ext_d = ext_q;
    brk_d = brk_q;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      case (byte_q)
        8'hE0:   ext_d = 1'b1;
        8'hF0:   brk_d = 1'b1;
        default: begin
          key_d = {~key_q[10], ~brk_q, ext_q, byte_q};
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  // Key word and prefix flag registers.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      key_q <= '0;
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      key_q <= key_d;
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = frame_err_q;

endmodule
